// File: rtl/param_flit_sink_if.sv
// Flit ingress / pop egress bundle for param_flit_sink.
// The sink side uses the slave modport; the traffic source uses master.
interface param_flit_sink_if #(
    parameter int unsigned num_vcs         = 4,
    parameter int unsigned flit_data_width = 64
) ();
    localparam int unsigned vc_idx_width = $clog2(num_vcs);

    logic                       flit_valid;
    logic [vc_idx_width-1:0]    flit_vc;
    logic                       flit_head;
    logic                       flit_tail;
    logic [flit_data_width-1:0] flit_data;
    logic                       consume_en;

    logic                       pop_valid;
    logic [vc_idx_width-1:0]    pop_vc;
    logic [flit_data_width-1:0] pop_data;
    logic                       pop_tail;
    logic [vc_idx_width:0]      flow_ctrl;

    modport master (
        output flit_valid, flit_vc, flit_head, flit_tail, flit_data, consume_en,
        input  pop_valid, pop_vc, pop_data, pop_tail, flow_ctrl
    );

    modport slave (
        input  flit_valid, flit_vc, flit_head, flit_tail, flit_data, consume_en,
        output pop_valid, pop_vc, pop_data, pop_tail, flow_ctrl
    );
endinterface

// File: rtl/param_flit_sink.sv
// Multi-VC flit sink: per-VC circular FIFOs, round-robin pop, credit return,
// per-VC packet framing checks, counters and sticky error reporting.
module param_flit_sink #(
    parameter int unsigned  num_vcs         = 4,
    parameter int unsigned  buffer_depth    = 8,
    parameter int unsigned  flit_data_width = 64,
    parameter int unsigned  count_width     = 32,
    localparam int unsigned vc_idx_width    = $clog2(num_vcs),
    localparam int unsigned occ_width       = $clog2(buffer_depth + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    param_flit_sink_if.slave               bus,
    output logic [num_vcs*occ_width-1:0]   occupancy_ivc,
    output logic [count_width-1:0]         pkt_count,
    output logic [count_width-1:0]         flit_count,
    output logic [1:0]                     error,
    output logic [vc_idx_width-1:0]        error_vc
);
    localparam int unsigned ptr_width = $clog2(buffer_depth);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } vc_state_e;

    // FIFO entry: {data, tail}
    logic [flit_data_width:0]   r_mem [num_vcs][buffer_depth];
    logic [ptr_width-1:0]       r_wr_ptr [num_vcs];
    logic [ptr_width-1:0]       r_rd_ptr [num_vcs];
    logic [occ_width-1:0]       r_occ [num_vcs];
    vc_state_e                  r_state [num_vcs];
    vc_state_e                  w_state_nxt [num_vcs];

    logic [vc_idx_width-1:0]    r_rr_ptr;
    logic                       r_pop_valid;
    logic [vc_idx_width-1:0]    r_pop_vc;
    logic [flit_data_width-1:0] r_pop_data;
    logic                       r_pop_tail;
    logic [count_width-1:0]     r_pkt_count;
    logic [count_width-1:0]     r_flit_count;
    logic [1:0]                 r_error;
    logic [vc_idx_width-1:0]    r_error_vc;

    logic                       w_grant_valid;
    logic [vc_idx_width-1:0]    w_grant_vc;
    logic [flit_data_width:0]   w_pop_entry;
    logic                       w_full;
    logic                       w_pop_same;
    logic                       w_push;
    logic                       w_overflow;
    logic                       w_proto_err;
    vc_state_e                  w_cur_state;
    logic [num_vcs-1:0]         w_push_vec;
    logic [num_vcs-1:0]         w_pop_vec;

    function automatic logic [vc_idx_width-1:0] rr_vc(input logic [vc_idx_width-1:0] base,
                                                      input int unsigned off);
        return vc_idx_width'((32'(base) + off) % num_vcs);
    endfunction

    function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
        return (p == ptr_width'(buffer_depth - 1)) ? '0 : p + ptr_width'(1);
    endfunction

    // Round-robin arbiter over non-empty VCs; lowest offset from r_rr_ptr wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_vc    = '0;
        for (int i = int'(num_vcs) - 1; i >= 0; i--) begin
            if (bus.consume_en && (r_occ[rr_vc(r_rr_ptr, unsigned'(i))] != '0)) begin
                w_grant_valid = 1'b1;
                w_grant_vc    = rr_vc(r_rr_ptr, unsigned'(i));
            end
        end
    end

    assign w_pop_entry = r_mem[w_grant_vc][r_rd_ptr[w_grant_vc]];

    // Push acceptance and per-VC framing FSM next state.
    always_comb begin
        w_full      = 1'b0;
        w_cur_state = ST_IDLE;
        for (int v = 0; v < int'(num_vcs); v++) begin
            if (bus.flit_vc == vc_idx_width'(v)) begin
                w_full      = (r_occ[v] == occ_width'(buffer_depth));
                w_cur_state = r_state[v];
            end
        end
        w_pop_same  = w_grant_valid && (w_grant_vc == bus.flit_vc);
        w_push      = bus.flit_valid && (!w_full || w_pop_same);
        w_overflow  = bus.flit_valid && w_full && !w_pop_same;
        w_proto_err = w_push && ((w_cur_state == ST_IDLE) ? !bus.flit_head : bus.flit_head);
        for (int v = 0; v < int'(num_vcs); v++) begin
            w_push_vec[v]  = w_push && (bus.flit_vc == vc_idx_width'(v));
            w_pop_vec[v]   = w_grant_valid && (w_grant_vc == vc_idx_width'(v));
            w_state_nxt[v] = r_state[v];
            if (w_push_vec[v]) begin
                w_state_nxt[v] = bus.flit_tail ? ST_IDLE : ST_IN_PKT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < int'(num_vcs); v++) begin
                r_state[v] <= ST_IDLE;
            end
        end else begin
            for (int v = 0; v < int'(num_vcs); v++) begin
                r_state[v] <= w_state_nxt[v];
            end
        end
    end

    // Storage is not reset; emptiness is defined by pointers and occupancy.
    always_ff @(posedge clk) begin
        for (int v = 0; v < int'(num_vcs); v++) begin
            if (w_push_vec[v]) begin
                r_mem[v][r_wr_ptr[v]] <= {bus.flit_data, bus.flit_tail};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < int'(num_vcs); v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_occ[v]    <= '0;
            end
            r_rr_ptr     <= '0;
            r_pop_valid  <= 1'b0;
            r_pop_vc     <= '0;
            r_pop_data   <= '0;
            r_pop_tail   <= 1'b0;
            r_pkt_count  <= '0;
            r_flit_count <= '0;
            r_error      <= '0;
            r_error_vc   <= '0;
        end else begin
            for (int v = 0; v < int'(num_vcs); v++) begin
                if (w_push_vec[v]) r_wr_ptr[v] <= ptr_inc(r_wr_ptr[v]);
                if (w_pop_vec[v])  r_rd_ptr[v] <= ptr_inc(r_rd_ptr[v]);
                if (w_push_vec[v] && !w_pop_vec[v]) begin
                    r_occ[v] <= r_occ[v] + occ_width'(1);
                end else if (w_pop_vec[v] && !w_push_vec[v]) begin
                    r_occ[v] <= r_occ[v] - occ_width'(1);
                end
            end

            r_pop_valid <= w_grant_valid;
            r_pop_tail  <= w_grant_valid && w_pop_entry[0];
            if (w_grant_valid) begin
                r_pop_vc     <= w_grant_vc;
                r_pop_data   <= w_pop_entry[flit_data_width:1];
                r_rr_ptr     <= rr_vc(w_grant_vc, 1);
                r_flit_count <= r_flit_count + count_width'(1);
                if (w_pop_entry[0]) r_pkt_count <= r_pkt_count + count_width'(1);
            end

            // error_vc captures only the first error since reset.
            if (w_overflow || w_proto_err) begin
                if (r_error == 2'b00) r_error_vc <= bus.flit_vc;
                r_error <= r_error | {w_proto_err, w_overflow};
            end
        end
    end

    generate
        for (genvar g = 0; g < int'(num_vcs); g++) begin : g_occ
            assign occupancy_ivc[g*occ_width +: occ_width] = r_occ[g];
        end
    endgenerate

    assign bus.pop_valid = r_pop_valid;
    assign bus.pop_vc    = r_pop_vc;
    assign bus.pop_data  = r_pop_data;
    assign bus.pop_tail  = r_pop_tail;
    assign bus.flow_ctrl = {r_pop_valid, r_pop_vc};
    assign pkt_count     = r_pkt_count;
    assign flit_count    = r_flit_count;
    assign error         = r_error;
    assign error_vc      = r_error_vc;
endmodule

// File: tb/tb_param_flit_sink.sv
// Scoreboard bench for param_flit_sink: expected pops are queued as stimulus
// is driven and retired by a monitor sampling on the falling edge.
module tb_param_flit_sink;
    localparam int unsigned NV = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 32;
    localparam int unsigned VW = $clog2(NV);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [VW-1:0] vc;
        logic [DW-1:0] data;
        logic          tail;
    } exp_t;

    logic clk;
    logic reset;
    logic [NV*OW-1:0] occupancy_ivc;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] flit_count;
    logic [1:0] error;
    logic [VW-1:0] error_vc;

    param_flit_sink_if #(.num_vcs(NV), .flit_data_width(DW)) bus ();

    param_flit_sink #(
        .num_vcs(NV), .buffer_depth(DEPTH), .flit_data_width(DW), .count_width(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .occupancy_ivc(occupancy_ivc),
        .pkt_count(pkt_count),
        .flit_count(flit_count),
        .error(error),
        .error_vc(error_vc)
    );

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_credits = 0;
    logic [DW-1:0] last_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] occ_of(input int vc);
        return occupancy_ivc[vc*OW +: OW];
    endfunction

    task automatic expect_pop(input logic [VW-1:0] vc, input logic [DW-1:0] d, input logic t);
        exp_t e;
        e.vc = vc;
        e.data = d;
        e.tail = t;
        q.push_back(e);
    endtask

    task automatic send(input logic [VW-1:0] vc, input logic h, input logic t, input logic [DW-1:0] d);
        bus.flit_valid = 1'b1;
        bus.flit_vc    = vc;
        bus.flit_head  = h;
        bus.flit_tail  = t;
        bus.flit_data  = d;
        @(posedge clk);
        #1;
        bus.flit_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.flit_valid = 1'b0;
        bus.consume_en = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", DW'(q.size()), '0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: retire one expectation per popped flit.
    always @(negedge clk) begin
        if (reset && bus.pop_valid) begin
            n_credits++;
            if (q.size() == 0) begin
                check("pop_unexpected", DW'(bus.pop_vc), '1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pop_vc", DW'(bus.pop_vc), DW'(e.vc));
                check("pop_data", bus.pop_data, e.data);
                check("pop_tail", DW'(bus.pop_tail), DW'(e.tail));
                check("flow_ctrl", DW'(bus.flow_ctrl), DW'({1'b1, e.vc}));
                last_data = e.data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.flit_valid = 1'b0;
        bus.flit_vc = '0;
        bus.flit_head = 1'b0;
        bus.flit_tail = 1'b0;
        bus.flit_data = '0;
        bus.consume_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pop_valid", DW'(bus.pop_valid), '0);
        check("rst_flow_ctrl", DW'(bus.flow_ctrl), '0);
        check("rst_occupancy", DW'(occupancy_ivc), '0);
        check("rst_flit_count", DW'(flit_count), '0);
        check("rst_error", DW'(error), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 3-flit packet on VC1 with consume enabled
        bus.consume_en = 1'b1;
        expect_pop(1, 64'h1001, 1'b0);
        expect_pop(1, 64'h1002, 1'b0);
        expect_pop(1, 64'h1003, 1'b1);
        send(1, 1'b1, 1'b0, 64'h1001);
        send(1, 1'b0, 1'b0, 64'h1002);
        send(1, 1'b0, 1'b1, 64'h1003);
        wait_drain(50);
        check("a_pkt_count", DW'(pkt_count), 64'd1);
        check("a_flit_count", DW'(flit_count), 64'd3);
        check("a_error", DW'(error), '0);
        check("a_occ1", DW'(occ_of(1)), '0);
        check("a_pop_data_hold", bus.pop_data, last_data);

        // overflow on VC0: ninth flit dropped
        do_reset();
        for (int i = 0; i < 8; i++) send(0, (i == 0), 1'b0, 64'h2000 + 64'(i));
        @(negedge clk);
        check("b_full_no_err", DW'(error), '0);
        send(0, 1'b0, 1'b0, 64'h2008);
        @(negedge clk);
        check("b_error", DW'(error), 64'd1);
        check("b_error_vc", DW'(error_vc), '0);
        check("b_occ0", DW'(occ_of(0)), 64'd8);

        // round-robin over VC0, VC2, VC3
        do_reset();
        for (int r = 0; r < 2; r++) begin
            send(0, (r == 0), (r == 1), 64'h3000 + 64'(r));
            send(2, (r == 0), (r == 1), 64'h3200 + 64'(r));
            send(3, (r == 0), (r == 1), 64'h3300 + 64'(r));
            expect_pop(0, 64'h3000 + 64'(r), (r == 1));
            expect_pop(2, 64'h3200 + 64'(r), (r == 1));
            expect_pop(3, 64'h3300 + 64'(r), (r == 1));
        end
        n_credits = 0;
        bus.consume_en = 1'b1;
        wait_drain(50);
        check("c_credits", 64'(n_credits), 64'd6);
        check("c_pkt_count", DW'(pkt_count), 64'd3);
        check("c_flit_count", DW'(flit_count), 64'd6);
        check("c_error", DW'(error), '0);

        // protocol errors: body on idle VC2, then head on busy VC3
        do_reset();
        send(3, 1'b1, 1'b0, 64'h4300);
        @(negedge clk);
        check("d_head_ok", DW'(error), '0);
        send(2, 1'b0, 1'b0, 64'h4200);
        @(negedge clk);
        check("d_err_first", DW'(error), 64'd2);
        send(3, 1'b1, 1'b0, 64'h4301);
        @(negedge clk);
        check("d_error", DW'(error), 64'd2);
        check("d_error_vc", DW'(error_vc), 64'd2);

        // full VC1 with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(1, (i == 0), (i == 7), 64'h5000 + 64'(i));
            expect_pop(1, 64'h5000 + 64'(i), (i == 7));
        end
        @(negedge clk);
        check("e_occ1_full", DW'(occ_of(1)), 64'd8);
        expect_pop(1, 64'h5008, 1'b1);
        bus.consume_en = 1'b1;
        send(1, 1'b1, 1'b1, 64'h5008);
        bus.consume_en = 1'b0;
        @(negedge clk);
        check("e_occ1_same", DW'(occ_of(1)), 64'd8);
        check("e_no_overflow", DW'(error), '0);
        bus.consume_en = 1'b1;
        wait_drain(60);
        check("e_flit_count", DW'(flit_count), 64'd9);
        check("e_pkt_count", DW'(pkt_count), 64'd2);
        check("e_error", DW'(error), '0);

        // reset mid-packet on VC0
        bus.consume_en = 1'b0;
        send(0, 1'b1, 1'b0, 64'h6000);
        #2;
        reset = 1'b0;
        #1;
        check("f_rst_pop_valid", DW'(bus.pop_valid), '0);
        check("f_rst_pop_vc", DW'(bus.pop_vc), '0);
        check("f_rst_pop_data", bus.pop_data, '0);
        check("f_rst_pop_tail", DW'(bus.pop_tail), '0);
        check("f_rst_flow_ctrl", DW'(bus.flow_ctrl), '0);
        check("f_rst_occ", DW'(occupancy_ivc), '0);
        check("f_rst_pkt_count", DW'(pkt_count), '0);
        check("f_rst_flit_count", DW'(flit_count), '0);
        check("f_rst_error_vc", DW'(error_vc), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(0, 1'b1, 1'b0, 64'h6001);
        @(negedge clk);
        check("f_no_proto_err", DW'(error), '0);
        check("f_occ0", DW'(occ_of(0)), 64'd1);
        expect_pop(0, 64'h6001, 1'b0);
        bus.consume_en = 1'b1;
        wait_drain(50);
        check("f_flit_count", DW'(flit_count), 64'd1);
        check("f_pkt_count", DW'(pkt_count), '0);
        check("f_pop_data_hold", bus.pop_data, 64'h6001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
